// File: rtl/imem_ctrl_pkg.sv
// Shared types for the instruction-memory load controller.
// HOLD: idle after reset, LOAD: accepting words, FLUSH: pipeline drain, RUN: core released.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_load_controller.sv
// Streams a program into the fetch-stage instruction memory; holds core_reset until FLUSH ends.
// Write latency 1 cycle; s_ready is high for the whole LOAD state, and a stalled s_valid waits forever.
module imem_load_controller
  import imem_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 256,
  parameter int NUM_COL      = 4,
  parameter int FLUSH_CYCLES = 4,
  localparam int LOGSIZE     = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_load,
  input  logic [LOGSIZE:0]   load_len,
  input  logic               s_valid,
  input  logic [WIDTH-1:0]   s_data,
  output logic               s_ready,
  output logic [WIDTH-1:0]   instr_in,
  output logic [LOGSIZE+1:0] wr_addr,
  output logic [NUM_COL-1:0] wr_en,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [LOGSIZE:0] SIZE_L     = (LOGSIZE + 1)'(SIZE);
  localparam logic [FCW-1:0]   FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

  state_t               r_state;
  logic [LOGSIZE:0]     r_len;
  logic [LOGSIZE-1:0]   r_wcnt;
  logic [FCW-1:0]       r_fcnt;
  logic [WIDTH-1:0]     r_instr;
  logic [LOGSIZE+1:0]   r_addr;
  logic [NUM_COL-1:0]   r_wr_en;
  logic                 r_done;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [LOGSIZE:0]     w_len_nxt;
  logic [LOGSIZE-1:0]   w_wcnt_nxt;
  logic [FCW-1:0]       w_fcnt_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_len_ok;

  assign w_ready  = (r_state == LOAD);
  assign w_hs     = s_valid && w_ready;
  assign w_last   = ({1'b0, r_wcnt} == (r_len - 1'b1));
  assign w_len_ok = (load_len != '0) && (load_len <= SIZE_L);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wcnt_nxt  = r_wcnt;
    w_fcnt_nxt  = r_fcnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      HOLD, RUN: begin
        if (start_load) begin
          if (w_len_ok) begin
            w_state_nxt = LOAD;
            w_len_nxt   = load_len;
            w_wcnt_nxt  = '0;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      LOAD: begin
        // The counter stops at len-1, so the byte address never runs past the last word.
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = FLUSH_INIT;
          end else begin
            w_wcnt_nxt  = r_wcnt + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (r_fcnt == '0) begin
          w_state_nxt = RUN;
          w_done_nxt  = 1'b1;
        end else begin
          w_fcnt_nxt  = r_fcnt - 1'b1;
        end
      end
      default: w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HOLD;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
      r_instr <= '0;
      r_addr  <= '0;
      r_wr_en <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_wr_en <= w_hs ? '1 : '0;
      if (w_hs) begin
        r_instr <= s_data;
        r_addr  <= {r_wcnt, 2'b00};
      end
    end
  end

  assign s_ready    = w_ready;
  assign instr_in   = r_instr;
  assign wr_addr    = r_addr;
  assign wr_en      = r_wr_en;
  assign core_reset = (r_state != RUN);
  assign busy       = (r_state == LOAD) || (r_state == FLUSH);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: acceptance table, directed load/flush/reset sequences, randomized programs.
module tb_imem_load_controller;

  localparam int W  = 32;
  localparam int SZ = 16;
  localparam int NC = 4;
  localparam int FC = 4;
  localparam int LS = $clog2(SZ);
  localparam int AW = LS + 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_load;
  logic [LS:0]   load_len;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic [W-1:0]  instr_in;
  logic [AW-1:0] wr_addr;
  logic [NC-1:0] wr_en;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_load_controller #(
    .WIDTH(W), .SIZE(SZ), .NUM_COL(NC), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_load(start_load), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .instr_in(instr_in),
    .wr_addr(wr_addr), .wr_en(wr_en), .core_reset(core_reset), .busy(busy),
    .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [NC-1:0] en;
    int            cyc;
  } wr_t;

  typedef struct {
    int len;
    bit accept;
  } vec_t;

  wr_t mon_wr[$];
  int  mon_done[$];
  int  mon_err[$];
  bit  cr_log[int];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    cr_log[cyc_n] = core_reset;
    if (wr_en != '0) mon_wr.push_back('{wr_addr, instr_in, wr_en, cyc_n});
    if (done) mon_done.push_back(cyc_n);
    if (err) mon_err.push_back(cyc_n);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_wr.delete();
    mon_done.delete();
    mon_err.delete();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start_load = 1'b0;
    s_valid    = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // Rejected start: one err pulse, state and outputs otherwise untouched.
  task automatic reject(input int len);
    logic cr0;
    clear_mon();
    cr0        = core_reset;
    start_load = 1'b1;
    load_len   = (LS + 1)'(len);
    cyc();
    start_load = 1'b0;
    chk("rej_err_pulse", 64'(err), 64'd1);
    chk("rej_busy", 64'(busy), 64'd0);
    chk("rej_core_reset_kept", 64'(core_reset), 64'(cr0));
    chk("rej_no_write", 64'(wr_en), 64'd0);
    cyc();
    chk("rej_err_one_cycle", 64'(err), 64'd0);
    chk("rej_err_count", 64'(mon_err.size()), 64'd1);
  endtask

  // Full program load: word k must land at byte address 4k, done FC cycles after the last write.
  task automatic run_load(input int len, input int gap, input bit rnd, input bit noise);
    logic [W-1:0] words[$];
    int i, budget, stall, idle, b2;
    bit hs;
    clear_mon();
    for (int k = 0; k < len; k++) words.push_back($urandom);
    start_load = 1'b1;
    load_len   = (LS + 1)'(len);
    cyc();
    start_load = 1'b0;
    chk("core_reset_after_start", 64'(core_reset), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
    i = 0; stall = 0; idle = 0;
    budget = len * (gap + 2) + 20;
    while (i < len && budget > 0) begin
      if (idle > 0) begin
        s_valid = 1'b0;
        idle--;
      end else begin
        s_valid = 1'b1;
      end
      s_data = s_valid ? words[i] : $urandom;
      if (!s_ready) stall++;
      if (noise) begin
        start_load = 1'($urandom_range(0, 1));
        load_len   = (LS + 1)'($urandom_range(0, 2 ** (LS + 1) - 1));
      end
      hs = s_valid && s_ready;
      cyc();
      if (hs) begin
        i++;
        idle = rnd ? $urandom_range(0, gap) : gap;
      end
      budget--;
    end
    s_valid    = 1'b0;
    start_load = 1'b0;
    chk("load_words_accepted", 64'(i), 64'(len));
    chk("s_ready_high_in_load", 64'(stall), 64'd0);
    b2 = FC + 10;
    while (done !== 1'b1 && b2 > 0) begin
      start_load = noise;
      load_len   = (LS + 1)'($urandom_range(0, 2 ** (LS + 1) - 1));
      cyc();
      b2--;
    end
    start_load = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    cyc();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("core_reset_run", 64'(core_reset), 64'd0);
    chk("busy_run", 64'(busy), 64'd0);
    chk("write_count", 64'(mon_wr.size()), 64'(len));
    for (int k = 0; k < len && k < mon_wr.size(); k++) begin
      chk("write_addr", 64'(mon_wr[k].addr), 64'(k * 4));
      chk("write_data", 64'(mon_wr[k].data), 64'(words[k]));
      chk("write_en", 64'(mon_wr[k].en), 64'((1 << NC) - 1));
    end
    chk("done_count", 64'(mon_done.size()), 64'd1);
    chk("err_count", 64'(mon_err.size()), 64'd0);
    if (mon_wr.size() > 0 && mon_done.size() > 0) begin
      chk("flush_len", 64'(mon_done[0] - mon_wr[mon_wr.size() - 1].cyc), 64'(FC));
      chk("core_reset_last_flush", 64'(cr_log[mon_done[0] - 1]), 64'd1);
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 1'b0};
    tbl[1] = '{1, 1'b1};
    tbl[2] = '{SZ, 1'b1};
    tbl[3] = '{SZ + 1, 1'b0};
    tbl[4] = '{2 ** (LS + 1) - 1, 1'b0};
    tbl[5] = '{5, 1'b1};

    reset_n = 1'b0; start_load = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
    cyc();
    cyc();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_instr_in", 64'(instr_in), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    cyc();
    chk("hold_core_reset", 64'(core_reset), 64'd1);

    // Acceptance of load_len from HOLD; accepted loads are aborted by reset.
    foreach (tbl[v]) begin
      start_load = 1'b1;
      load_len   = (LS + 1)'(tbl[v].len);
      cyc();
      start_load = 1'b0;
      chk("tbl_err", 64'(err), 64'(!tbl[v].accept));
      chk("tbl_busy", 64'(busy), 64'(tbl[v].accept));
      chk("tbl_s_ready", 64'(s_ready), 64'(tbl[v].accept));
      chk("tbl_core_reset", 64'(core_reset), 64'd1);
      chk("tbl_wr_en", 64'(wr_en), 64'd0);
      do_reset();
    end

    run_load(3, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b0, 1'b0);
    reject(0);
    reject(SZ + 1);
    do_reset();
    reject(0);
    reject(SZ + 1);
    run_load(2, 3, 1'b0, 1'b0);
    run_load(4, 1, 1'b1, 1'b1);
    run_load(SZ, 0, 1'b0, 1'b0);

    // Reset mid-load: abort at once, the single written word stays, no done.
    clear_mon();
    start_load = 1'b1;
    load_len   = (LS + 1)'(4);
    cyc();
    start_load = 1'b0;
    s_valid    = 1'b1;
    s_data     = 32'hCAFE_0001;
    cyc();
    s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("midrst_writes", 64'(mon_wr.size()), 64'd1);
    chk("midrst_done", 64'(mon_done.size()), 64'd0);
    chk("midrst_still_hold", 64'(core_reset), 64'd1);

    for (int r = 0; r < 25; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) reject(0);
      else if (sel == 1) reject($urandom_range(SZ + 1, 2 ** (LS + 1) - 1));
      else run_load($urandom_range(1, SZ), $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_load_controller.md
IMEM_LOAD_CONTROLLER -- requirements
Module: imem_load_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per instruction word.
REQ-002 SHALL have parameter SIZE, default 256: instruction memory depth in words; LOGSIZE = clog2(SIZE) is a localparam.
REQ-003 SHALL have parameter NUM_COL, default 4: byte-lane write enables per word.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 4: cycles core_reset stays high after the last word is written.
REQ-005 SHALL have port clk  input  1  the single clock; every register is on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_load  input  1  single-cycle request to begin a program load.
REQ-008 SHALL have port load_len  input  LOGSIZE+1  word count, sampled when start_load is accepted.
REQ-009 SHALL have port s_valid  input  1  loader word valid.
REQ-010 SHALL have port s_data  input  WIDTH  loader word.
REQ-011 SHALL have port s_ready  output  1  controller accepts a word this cycle.
REQ-012 SHALL have port instr_in  output  WIDTH  word to the fetch-stage memory write port.
REQ-013 SHALL have port wr_addr  output  LOGSIZE+2  byte address to the fetch-stage write port.
REQ-014 SHALL have port wr_en  output  NUM_COL  byte-lane write enables.
REQ-015 SHALL have port core_reset  output  1  active-high reset held on the pipeline and PC.
REQ-016 SHALL have port busy  output  1  high in LOAD or FLUSH.
REQ-017 SHALL have port done  output  1  one-cycle pulse on entry to RUN.
REQ-018 SHALL have port err  output  1  one-cycle pulse when start_load is rejected.

Function
REQ-019 SHALL implement the states HOLD, LOAD, FLUSH and RUN.
REQ-020 In HOLD or RUN, a start_load with 1 <= load_len <= SIZE SHALL move the FSM to LOAD, capture load_len and clear the word counter.
REQ-021 In HOLD or RUN, a start_load with load_len == 0 or load_len > SIZE SHALL pulse err on the next cycle, leave the state unchanged and write nothing.
REQ-022 start_load SHALL be ignored in LOAD and FLUSH, with no err pulse.
REQ-023 s_ready SHALL equal (state == LOAD), combinationally from state only.
REQ-024 A handshake is s_valid && s_ready at a rising edge.
REQ-025 At the edge of handshake k, the controller SHALL register instr_in = s_data, wr_addr = {k, 2'b00} and wr_en = all ones, visible for exactly one cycle; write latency is 1 cycle.
REQ-026 In any cycle without a write, wr_en SHALL be zero; instr_in and wr_addr hold their last values.
REQ-027 The handshake with k == len-1 SHALL move the FSM to FLUSH and load the flush counter with FLUSH_CYCLES-1.
REQ-028 FLUSH SHALL decrement the counter each cycle and move to RUN on the cycle after the counter reads 0, so FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-029 core_reset SHALL be 1 in HOLD, LOAD and FLUSH, and 0 only in RUN.
REQ-030 done SHALL be 1 in the first RUN cycle only.
REQ-031 A start_load accepted in RUN SHALL drive core_reset to 1 in the very next cycle.
REQ-032 The word counter SHALL never exceed len-1, so wr_addr never wraps past SIZE words.
REQ-033 s_valid held low in LOAD SHALL stall the load indefinitely, with no timeout.

Reset
REQ-034 While reset_n is 0, the controller SHALL set state = HOLD, counters = 0, s_ready = 0, wr_en = 0, instr_in = 0, wr_addr = 0, core_reset = 1, busy = 0, done = 0 and err = 0.
REQ-035 Reset asserted mid-LOAD or mid-FLUSH SHALL abort immediately to HOLD with no further writes; the words already written are left in memory.

Structure
REQ-036 The package imem_ctrl_pkg SHALL hold the state enum (HOLD, LOAD, FLUSH, RUN).
REQ-037 There SHALL be no sub-module: one FSM and two counters inline; the outputs feed the fetch stage's instr_in, wr_addr and wr_en write port.

Verification
REQ-038 Reset, then start_load with len = 3 and words A, B, C on back-to-back s_valid -> writes at wr_addr 0x0, 0x4, 0x8 with wr_en = 4'hF, core_reset stays high 4 cycles after the last write, then done pulses once and core_reset = 0.
REQ-039 start_load with len = 0, then with len = SIZE+1 -> err pulses once for each, state stays HOLD, wr_en stays 0.
REQ-040 len = 2 with s_valid gapped 3 cycles between words -> exactly 2 writes at addresses 0x0 and 0x4, s_ready high throughout LOAD.
REQ-041 In RUN, start_load with len = 1 -> core_reset rises on the next cycle, one write at 0x0, done pulses again.
REQ-042 reset_n pulsed low after 1 of 4 words -> immediate HOLD, wr_en = 0, no done pulse.
REQ-043 start_load pulsed during FLUSH -> ignored, no err, FLUSH length unchanged.
